// File: rtl/alu_disp_pkg.sv
// -----------------------------------------------------------------------------
// alu_disp_pkg
// Shared definitions for the ALU result display:
//   - FSM state encoding (BLANK / SCAN / PENDING)
//   - ALU result record held in the shadow and display registers
//   - active-high 7-segment patterns {g,f,e,d,c,b,a} for 0-F, 'A', 'L', blank
//   - display symbol codes and the symbol -> pattern lookup
// -----------------------------------------------------------------------------
package alu_disp_pkg;

    localparam logic [1:0] ST_BLANK   = 2'd0;
    localparam logic [1:0] ST_SCAN    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    typedef struct packed {
        logic [3:0] s;
        logic       cout;
        logic [2:0] op;
        logic       m;
    } alu_result_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Symbol codes: 0..15 are hex digits (so 'A' shares code 10), then extras.
    localparam logic [4:0] SYM_A     = 5'd10;
    localparam logic [4:0] SYM_L     = 5'd16;
    localparam logic [4:0] SYM_BLANK = 5'd17;

    function automatic logic [6:0] seg_pattern(input logic [4:0] sym);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (sym)
            5'd0:    pat = SEG_0;
            5'd1:    pat = SEG_1;
            5'd2:    pat = SEG_2;
            5'd3:    pat = SEG_3;
            5'd4:    pat = SEG_4;
            5'd5:    pat = SEG_5;
            5'd6:    pat = SEG_6;
            5'd7:    pat = SEG_7;
            5'd8:    pat = SEG_8;
            5'd9:    pat = SEG_9;
            5'd10:   pat = SEG_A;
            5'd11:   pat = SEG_B;
            5'd12:   pat = SEG_C;
            5'd13:   pat = SEG_D;
            5'd14:   pat = SEG_E;
            5'd15:   pat = SEG_F;
            SYM_L:   pat = SEG_L;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg7_hex_decoder
// Combinational symbol -> 7-segment decoder with selectable output polarity.
// Ports:
//   sym        in  5  symbol code (0-15 hex, SYM_L, anything else blank)
//   active_low in  1  1: invert pattern for active-low segment drivers
//   seg        out 7  segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decoder
    import alu_disp_pkg::*;
(
    input  logic [4:0] sym,
    input  logic       active_low,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_pattern(sym) ^ {7{active_low}};
    end

endmodule

// File: rtl/alu_result_display.sv
// -----------------------------------------------------------------------------
// alu_result_display
// Accepts ALU results on a valid/ready handshake and shows them on a 4-digit
// multiplexed 7-segment display: digit0 = s (hex), digit1 = carry, digit2 = Op,
// digit3 = 'A' (M=1) or 'L' (M=0). A new result is parked in a shadow register
// and copied to the display register only at a frame boundary, so one frame
// never mixes old and new data.
// Optional feature macro: CARRY_BLINK_EN -- when defined, all digits blank for
// alternate groups of BLINK_FRAMES frames while the displayed carry is 1
// (visible group first after each commit).
// Ports:
//   clk, rst (async, active-high)
//   ld_valid/ld_ready  handshake; ld_s[3:0], ld_cout, ld_op[2:0], ld_m data
//   seg[6:0] {g,f,e,d,c,b,a}, dp (always off), an[3:0] (an[0] = digit0)
// -----------------------------------------------------------------------------
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 100000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_s,
    input  logic       ld_cout,
    input  logic [2:0] ld_op,
    input  logic       ld_m,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic             ACT_LOW = (SEG_ACTIVE_LOW != 0);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be >= 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be >= 1");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    alu_result_t      shadow_q, shadow_d;
    alu_result_t      disp_q, disp_d;
    logic             disp_vld_q, disp_vld_d;
    logic [6:0]       seg_q;
    logic [3:0]       an_q, an_d;

    logic             tc;
    logic             boundary;
    logic             accept;
    logic             commit;
    logic             show;
    logic             blink_blank;
    logic [4:0]       sym;
    logic [6:0]       seg_dec;

    assign ld_ready = (state_q != ST_PENDING);
    assign accept   = ld_valid && ld_ready;
    assign tc       = (cnt_q == CNT_MAX);
    assign boundary = tc && (idx_q == 2'd3);
    assign commit   = (state_q == ST_PENDING) && boundary;

    // Refresh counter and digit index run in every state, including BLANK.
    always_comb begin
        cnt_d = tc ? '0 : cnt_q + 1'b1;
        idx_d = tc ? idx_q + 2'd1 : idx_q;
    end

    // Handshake FSM. An accept on a boundary cycle lands in PENDING after that
    // boundary, so it commits at the following one.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        disp_d     = disp_q;
        disp_vld_d = disp_vld_q;
        case (state_q)
            ST_BLANK, ST_SCAN: begin
                if (accept) begin
                    shadow_d = '{s: ld_s, cout: ld_cout, op: ld_op, m: ld_m};
                    state_d  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (boundary) begin
                    disp_d     = shadow_q;
                    disp_vld_d = 1'b1;
                    state_d    = ST_SCAN;
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

`ifdef CARRY_BLINK_EN
    localparam int               BLK_W   = $clog2(BLINK_FRAMES + 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_FRAMES - 1);

    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blk_phase_q, blk_phase_d;

    // Frame counter restarts on commit so every new result starts visible.
    always_comb begin
        blk_cnt_d   = blk_cnt_q;
        blk_phase_d = blk_phase_q;
        if (commit) begin
            blk_cnt_d   = '0;
            blk_phase_d = 1'b0;
        end else if (boundary) begin
            if (blk_cnt_q == BLK_MAX) begin
                blk_cnt_d   = '0;
                blk_phase_d = ~blk_phase_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end
        blink_blank = disp_q.cout && blk_phase_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q   <= '0;
            blk_phase_q <= 1'b0;
        end else begin
            blk_cnt_q   <= blk_cnt_d;
            blk_phase_q <= blk_phase_d;
        end
    end
`else
    always_comb begin
        blink_blank = 1'b0;
    end
`endif

    // Digit mux. Slot cycle 0 is forced dark so the previous digit's segments
    // never flash on the next anode.
    always_comb begin
        show = disp_vld_q && (cnt_q != '0) && !blink_blank;
        case (idx_q)
            2'd0:    sym = {1'b0, disp_q.s};
            2'd1:    sym = {4'b0000, disp_q.cout};
            2'd2:    sym = {2'b00, disp_q.op};
            default: sym = disp_q.m ? SYM_A : SYM_L;
        endcase
        if (!show) begin
            sym = SYM_BLANK;
        end
        an_d = (show ? (4'b0001 << idx_q) : 4'b0000) ^ {4{ACT_LOW}};
    end

    seg7_hex_decoder u_dec (
        .sym        (sym),
        .active_low (ACT_LOW),
        .seg        (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            shadow_q   <= '0;
            disp_q     <= '0;
            disp_vld_q <= 1'b0;
            seg_q      <= {7{ACT_LOW}};
            an_q       <= {4{ACT_LOW}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            disp_vld_q <= disp_vld_d;
            seg_q      <= seg_dec;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = ACT_LOW;

endmodule
